lem_world_tracker: RTL and testbench
====================================

Name: lem_world_tracker

Overview:
- Sits directly downstream of the 2-D Lemmings walker FSM and closes the loop back to it.
- Consumes walk_left/walk_right and tracks the lemming's position in a 1-D corridor of WIDTH cells, advancing one cell every STEP_DIV clocks.
- Generates the bump_left/bump_right pulses that feed back into the walker when a wall is reached.
- Also flags illegal walker outputs and counts reversals for debug/scoreboarding.

Parameters:
- WIDTH, 16, number of corridor cells, legal range 2..256.
- STEP_DIV, 4, clocks per movement step, legal range 1..65535.
- START_POS, 0, position loaded at reset, must be < WIDTH.
- TURN_W, 8, width of the saturating reversal counter.

Ports:
- clk  in  1  system clock, rising edge.
- areset_n  in  1  synchronous active-low reset.
- walk_left  in  1  walker FSM output, moving left.
- walk_right  in  1  walker FSM output, moving right.
- pos  out  $clog2(WIDTH)  current cell index, 0 = left wall side.
- bump_left  out  1  one-cycle pulse, left wall hit; feeds walker bump_left.
- bump_right  out  1  one-cycle pulse, right wall hit; feeds walker bump_right.
- step_pulse  out  1  one-cycle pulse marking a movement tick.
- turn_count  out  TURN_W  number of bumps issued, saturating.
- dir_error  out  1  sticky flag, illegal walk encoding seen.

Behaviour:
- Interface: one clock, clk. Reset areset_n is synchronous and active-low, sampled only on the rising edge of clk. All outputs are registered.
- Reset values: pos=START_POS, bump_left=0, bump_right=0, step_pulse=0, turn_count=0, dir_error=0, tick counter=0, state=S_RUN. Reset asserted mid-step aborts the step immediately; no pulse leaks out in the reset cycle or the cycle after.
- Prescaler: tick_cnt counts 0..STEP_DIV-1 and wraps. The edge on which tick_cnt==STEP_DIV-1 is the step edge. With STEP_DIV=1 every edge is a step edge.
- States:
  - S_RUN: normal tracking.
  - S_FAULT: position frozen, no bumps, step_pulse still toggles.
- Transitions:
  - S_RUN -> S_FAULT on any edge where walk_left==walk_right, sampled every cycle, not just on step edges. dir_error=1 from the following cycle.
  - S_FAULT -> S_RUN only via reset.
- Step edge in S_RUN, registered into the next cycle:
  - step_pulse=1 for exactly one cycle.
  - walk_left and pos!=0: pos-1.
  - walk_left and pos==0: pos unchanged, bump_left=1 for one cycle, turn_count+1.
  - walk_right and pos!=WIDTH-1: pos+1.
  - walk_right and pos==WIDTH-1: pos unchanged, bump_right=1 for one cycle, turn_count+1.
- bump_left and bump_right are never high simultaneously. Both are low on all non-step cycles.
- Walker reverses on the edge after the bump. The next step edge then moves pos away from the wall; no double-bump is possible for STEP_DIV>=2.
- STEP_DIV=1 (bump and reversal on consecutive edges): the wall cell is held one extra step (no move on the step edge in which the walker is still sampled pointing at the wall).
- turn_count saturates at 2^TURN_W-1, with no wrap.
- Direction change between step edges: only the value sampled on the step edge matters.

Optional Feature:
- Macro: LEM_WRAP_EN.
- Defined: toroidal corridor. Stepping left at 0 loads WIDTH-1; stepping right at WIDTH-1 loads 0. bump_left and bump_right are tied to 0. turn_count instead counts wrap events, still saturating.
- Undefined: walled corridor exactly as described under Behaviour.

Decomposition:
- Package lem_pkg holds:
  - state enum {S_RUN, S_FAULT}.
  - direction localparams DIR_L=1'b0, DIR_R=1'b1.
  - a shared clog2-based POS_W helper function.
- Sub-module lem_step_timer (STEP_DIV prescaler) outputs the step-edge strobe. It is reusable by future multi-lemming blocks. All position, bump and fault logic stays in the top.

Test Plan (WIDTH=8, STEP_DIV=4, START_POS=0, closed loop with the walker FSM unless noted):
- Reset release, walker walking left at pos 0 -> first step edge at clk 4. Cycle after: bump_left=1 for 1 cycle, pos=0, turn_count=1. Walker turns right. pos=1 at the next step.
- Walk right from pos 0 -> pos reaches 7 after 7 steps (28 clks). Next step: bump_right=1 for 1 cycle, turn_count increments, pos stays 7, then decrements to 6.
- Open loop, force walk_left=walk_right=1 mid-step -> dir_error=1 the next cycle. pos frozen at its current value for the next 10 steps. No bumps. step_pulse still every 4 clks.
- Assert areset_n=0 on the cycle a step edge is due at pos=5 -> pos=START_POS (0). No step_pulse or bump in either the reset cycle or the cycle after. dir_error cleared.
- Free-run bouncing 2000 clks with TURN_W=3 -> turn_count saturates at 7 and holds.
- With LEM_WRAP_EN defined, walk left from pos 0 -> pos=7 after one step. bump_left stays 0. turn_count=1.

Source files
------------

// File: rtl/lem_pkg.sv
// Shared types and helpers for the lemming world tracker and its step timer.
package lem_pkg;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    // Width of a cell index for a corridor of the given number of cells.
    function automatic int pos_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/lem_step_timer.sv
// STEP_DIV prescaler: strobes step during the last clock of every STEP_DIV-clock period.
module lem_step_timer #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic areset_n,
    output logic step
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] tick_cnt;

    always_ff @(posedge clk) begin
        if (!areset_n)
            tick_cnt <= '0;
        else if (tick_cnt == LAST)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CW'(1);
    end

    assign step = (tick_cnt == LAST);

endmodule

// File: rtl/lem_world_tracker.sv
// Tracks a walker's position in a 1-D corridor and feeds wall bumps back to it.
// Define LEM_WRAP_EN for a toroidal corridor (wrap instead of bump).
module lem_world_tracker
    import lem_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int STEP_DIV  = 4,
    parameter int START_POS = 0,
    parameter int TURN_W    = 8
) (
    input  logic                     clk,
    input  logic                     areset_n,
    input  logic                     walk_left,
    input  logic                     walk_right,
    output logic [pos_w(WIDTH)-1:0]  pos,
    output logic                     bump_left,
    output logic                     bump_right,
    output logic                     step_pulse,
    output logic [TURN_W-1:0]        turn_count,
    output logic                     dir_error
);

    localparam int PW = pos_w(WIDTH);
    localparam logic [PW-1:0]     LAST_POS = PW'(WIDTH - 1);
    localparam logic [PW-1:0]     INIT_POS = PW'(START_POS);
    localparam logic [TURN_W-1:0] TC_MAX   = '1;

    state_t              state, state_nxt;
    logic                step;
    logic                legal;
    logic                move_en;
    logic                dir;
    logic [TURN_W-1:0]   tc_inc;

    lem_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
        .clk      (clk),
        .areset_n (areset_n),
        .step     (step)
    );

    assign legal  = walk_left ^ walk_right;
    assign dir    = walk_right ? DIR_R : DIR_L;
    assign tc_inc = (turn_count == TC_MAX) ? turn_count : turn_count + TURN_W'(1);

    always_ff @(posedge clk) begin
        if (!areset_n)
            state <= S_RUN;
        else
            state <= state_nxt;
    end

    // Fault is sticky until reset; the encoding is checked on every edge.
    always_comb begin
        state_nxt = state;
        if (state == S_RUN && !legal)
            state_nxt = S_FAULT;
    end

    always_comb begin
        move_en   = (state == S_RUN) && legal;
        dir_error = (state == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            pos        <= INIT_POS;
            bump_left  <= 1'b0;
            bump_right <= 1'b0;
            step_pulse <= 1'b0;
            turn_count <= '0;
        end else begin
            step_pulse <= step;
            bump_left  <= 1'b0;
            bump_right <= 1'b0;
            if (step && move_en) begin
                if (dir == DIR_L) begin
                    if (pos != '0) begin
                        pos <= pos - PW'(1);
                    end else begin
`ifdef LEM_WRAP_EN
                        pos        <= LAST_POS;
                        turn_count <= tc_inc;
`else
                        // A bump still high means the walker has not turned yet (STEP_DIV=1): hold.
                        if (!bump_left) begin
                            bump_left  <= 1'b1;
                            turn_count <= tc_inc;
                        end
`endif
                    end
                end else begin
                    if (pos != LAST_POS) begin
                        pos <= pos + PW'(1);
                    end else begin
`ifdef LEM_WRAP_EN
                        pos        <= '0;
                        turn_count <= tc_inc;
`else
                        if (!bump_right) begin
                            bump_right <= 1'b1;
                            turn_count <= tc_inc;
                        end
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lem_world_tracker.sv
// Scoreboard bench: a behavioural corridor model plus walker pushes expected outputs, a monitor compares.
module tb_lem_world_tracker;

    localparam int W  = 8;
    localparam int SD = 4;
    localparam int SP = 0;
    localparam int TW = 3;
    localparam int TC_MAX = (1 << TW) - 1;

    typedef struct {
        int pos;
        bit bl;
        bit br;
        bit sp;
        int tc;
        bit de;
    } exp_t;

    logic          clk = 1'b0;
    logic          areset_n = 1'b0;
    logic          walk_left = 1'b1;
    logic          walk_right = 1'b0;
    logic [2:0]    pos;
    logic          bump_left, bump_right, step_pulse, dir_error;
    logic [TW-1:0] turn_count;

    int checks = 0;
    int failures = 0;
    bit done = 1'b0;
    bit done_chk = 1'b0;
    exp_t sb[$];

    // Model state: cycles since reset release, position, pulses, counters, fault, walker heading.
    int m_cyc = 0, m_pos = SP, m_tc = 0;
    bit m_bl = 0, m_br = 0, m_sp = 0, m_fault = 0;
    bit walker_left = 1'b1;

    lem_world_tracker #(.WIDTH(W), .STEP_DIV(SD), .START_POS(SP), .TURN_W(TW)) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .pos        (pos),
        .bump_left  (bump_left),
        .bump_right (bump_right),
        .step_pulse (step_pulse),
        .turn_count (turn_count),
        .dir_error  (dir_error)
    );

    always #5 clk = ~clk;

    function automatic bit next_is_step();
        return (m_cyc % SD) == SD - 1;
    endfunction

    // mode 0: closed loop, 1: closed loop with between-step glitches, 2: illegal encoding, 3: open-loop random legal
    task automatic cycle(input bit rst_n, input int mode);
        bit wl, wr, step, legal;
        int npos, ntc;
        bit nbl, nbr;
        exp_t e;
        wl = walker_left;
        if (mode == 1 && !next_is_step() && ($urandom % 3 == 0)) wl = ~wl;
        if (mode == 3) wl = $urandom % 2;
        wr = ~wl;
        if (mode == 2) begin wl = 1'b1; wr = 1'b1; end
        areset_n = rst_n;
        walk_left = wl;
        walk_right = wr;
        @(posedge clk);
        if (!rst_n) begin
            m_cyc = 0; m_pos = SP; m_tc = 0;
            m_bl = 0; m_br = 0; m_sp = 0; m_fault = 0;
        end else begin
            step = next_is_step();
            m_cyc++;
            legal = wl != wr;
            npos = m_pos; ntc = m_tc; nbl = 0; nbr = 0;
            if (!m_fault && legal && step) begin
                if (wl) begin
                    if (m_pos > 0) npos = m_pos - 1;
`ifdef LEM_WRAP_EN
                    else begin npos = W - 1; ntc = (m_tc < TC_MAX) ? m_tc + 1 : m_tc; end
`else
                    else if (!m_bl) begin nbl = 1; ntc = (m_tc < TC_MAX) ? m_tc + 1 : m_tc; end
`endif
                end else begin
                    if (m_pos < W - 1) npos = m_pos + 1;
`ifdef LEM_WRAP_EN
                    else begin npos = 0; ntc = (m_tc < TC_MAX) ? m_tc + 1 : m_tc; end
`else
                    else if (!m_br) begin nbr = 1; ntc = (m_tc < TC_MAX) ? m_tc + 1 : m_tc; end
`endif
                end
            end
            if (!legal) m_fault = 1;
            // The walker reacts to the bump it sees during this cycle.
            if (walker_left && m_bl) walker_left = 1'b0;
            else if (!walker_left && m_br) walker_left = 1'b1;
            m_pos = npos; m_tc = ntc; m_bl = nbl; m_br = nbr; m_sp = step;
        end
        e.pos = m_pos; e.bl = m_bl; e.br = m_br; e.sp = m_sp; e.tc = m_tc; e.de = m_fault;
        sb.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (pos !== 3'(e.pos) || bump_left !== e.bl || bump_right !== e.br ||
                step_pulse !== e.sp || turn_count !== TW'(e.tc) || dir_error !== e.de) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL outputs t=%0t got pos=%0d bl=%b br=%b sp=%b tc=%0d de=%b want pos=%0d bl=%b br=%b sp=%b tc=%0d de=%b",
                             $time, pos, bump_left, bump_right, step_pulse, turn_count, dir_error,
                             e.pos, e.bl, e.br, e.sp, e.tc, e.de);
            end
        end else if (done && !done_chk) begin
            done_chk = 1'b1;
            checks++;
            if (sb.size() != 0) begin
                failures++;
                $display("FAIL drain got %0d pending want 0", sb.size());
            end
        end
    end

    initial begin
        int guard;
        // Left walker at the left wall: bump, turn, move away.
        walker_left = 1'b1;
        repeat (3) cycle(1'b0, 0);
        repeat (40) cycle(1'b1, 0);

        // Right walker from 0 to the right wall and back.
        walker_left = 1'b0;
        repeat (2) cycle(1'b0, 0);
        repeat (44) cycle(1'b1, 0);

        // Illegal encoding mid-step, then open-loop random legal inputs while frozen.
        walker_left = 1'b0;
        repeat (2) cycle(1'b0, 0);
        repeat (9) cycle(1'b1, 0);
        cycle(1'b1, 2);
        repeat (44) cycle(1'b1, 3);

        // Reset landing exactly on a due step edge with pos=5.
        walker_left = 1'b0;
        repeat (2) cycle(1'b0, 0);
        guard = 0;
        while (!(m_pos == 5 && next_is_step()) && guard < 100) begin
            cycle(1'b1, 0);
            guard++;
        end
        if (guard >= 100) begin
            failures++;
            $display("FAIL reach_pos5 got guard=%0d want <100", guard);
        end
        cycle(1'b0, 0);
        repeat (6) cycle(1'b1, 0);

        // Long closed-loop bounce with random between-step direction glitches; counter saturates.
        walker_left = $urandom % 2;
        repeat (2) cycle(1'b0, 0);
        repeat (2000) cycle(1'b1, 1);

        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
